instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encoder counterpart of the opcode/funct control decoder.
- Accepts symbolic instruction requests (mnemonic enum plus register, immediate and target fields) over a valid/ready handshake.
- Encodes each request into a 32-bit MIPS word and writes it sequentially into instruction memory from BASE_ADDR.
- Used by benches and the boot path to load programs that the decoder then executes.

Parameters:
- ADDR_W, 8, instruction memory word-address width.
- BASE_ADDR, 0, first word address written after start.
- DEPTH, 256, maximum words per load; must satisfy DEPTH <= 2^ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new load; counter returns to BASE_ADDR.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_op  in  5  mnemonic enum (see Behaviour).
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_imm  in  16  immediate/offset field.
- in_target  in  26  jump target field.
- in_last  in  1  this request is the final word of the program.
- mem_we  out  1  instruction memory write strobe, one-cycle pulse.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written since start.
- done  out  1  load complete, level.
- err_op  out  1  sticky: an illegal in_op was presented.
- overflow  out  1  sticky: a request arrived after DEPTH words were written.

Behaviour:
- Reset (rst=1 at a clk edge) applies from any state, including mid-write. Result: state IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, done=0, err_op=0, overflow=0.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE: in_ready=0. start -> LOAD; count and address cleared, err_op and overflow cleared.
- LOAD: in_ready=1. On in_valid&in_ready with a legal op:
  - encode combinationally and register into mem_wdata;
  - latch address;
  - go to WRITE;
  - in_last is captured.
- LOAD with an illegal op (20..31): request consumed, nothing written, err_op<=1, count unchanged, stays in LOAD. If in_last is also set, go to DONE.
- LOAD when count==DEPTH and a request is accepted: request dropped, overflow<=1, go to DONE.
- WRITE: mem_we=1 for exactly one cycle; in_ready=0. Next edge:
  - count+1, address+1;
  - go to DONE if captured in_last, else LOAD.
- Latency and throughput: request accepted at edge N gives mem_we high during cycle N+1. Maximum throughput is one word per 2 cycles.
- DONE: done=1, in_ready=0. start -> LOAD with clears as in IDLE.
- start in LOAD aborts the current load and restarts from BASE_ADDR with all clears. start in WRITE is ignored; the write completes.
- Address never wraps. The DEPTH limit is enforced via overflow.
- Encoding formats:
  - R: {000000, rs, rt, rd, 00000, funct}.
  - I: {opcode, rs, rt, imm}.
  - J: {opcode, target}.
- Enum -> encoding:
  - 0 ADD funct 100000; 1 SUB 100010; 2 AND 100100; 3 OR 100101; 4 SLT 101010.
  - 5 JR {000000, rs, 0, 0, 0, 001000}.
  - 6 JALR {000000, rs, 0, rd, 0, 001001}.
  - 7 ADDI 001000; 8 ANDI 001100; 9 ORI 001101; 10 XORI 001110.
  - 11 BEQ 000100; 12 BNE 000101.
  - 13 BGEZ {000001, rs, 00001, imm}; 14 BGEZAL {000001, rs, 10001, imm}.
  - 15 LW 100011; 16 SW 101011.
  - 17 MUL {011100, rs, rt, rd, 00000, 000010}.
  - 18 J 000010; 19 JAL 000011.
- Field rules: unused fields are forced to zero regardless of input, e.g. in_imm is ignored for R-type and in_rt is ignored for REGIMM. Immediates are passed unmodified; there is no sign handling.
- mem_addr and mem_wdata hold their last values outside WRITE.

Test Plan:
- Reset, start, then ADDI rt=8 rs=0 imm=5 -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0x20080005; count=1.
- Back-to-back stream:
  - ADD rd=10 rs=8 rt=9 -> 0x01095020 @0;
  - LW rt=8 rs=29 imm=4 -> 0x8FA80004 @1;
  - J target=0x10 with in_last -> 0x08000010 @2.
  - Required: in_ready low on each WRITE cycle, done=1 afterwards, count=3.
- BGEZAL rs=4 imm=0xFFFE with in_rt=7 -> 0x0491FFFE (rt field forced to 10001); BGEZ same fields -> 0x0481FFFE.
- in_op=25 mid-stream -> no mem_we, err_op=1 sticky, next legal word is written at the unchanged address; a later start clears err_op.
- DEPTH=4 build: 5 requests without in_last -> 4 writes at 0..3, 5th dropped, overflow=1, done=1, count=4.
- rst asserted during WRITE -> next cycle mem_we=0, state IDLE, count=0; start restarts at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instruction requests into 32-bit MIPS words and writes
// them sequentially into instruction memory starting at BASE_ADDR.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err_op,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t              state;
  logic [ADDR_W-1:0]   wr_addr;
  logic                last_p0;
  logic [31:0]         enc_word;
  logic                op_legal;

  // Unused fields are tied to zero so stray input bits never leak into a word.
  function automatic logic [31:0] encode(input logic [4:0]  op,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [4:0]  rd,
                                         input logic [15:0] imm,
                                         input logic [25:0] target);
    logic [31:0] w;
    case (op)
      5'd0:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      5'd1:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      5'd2:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      5'd3:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      5'd4:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      5'd5:    w = {6'b000000, rs, 5'b00000, 5'b00000, 5'b00000, 6'b001000};
      5'd6:    w = {6'b000000, rs, 5'b00000, rd, 5'b00000, 6'b001001};
      5'd7:    w = {6'b001000, rs, rt, imm};
      5'd8:    w = {6'b001100, rs, rt, imm};
      5'd9:    w = {6'b001101, rs, rt, imm};
      5'd10:   w = {6'b001110, rs, rt, imm};
      5'd11:   w = {6'b000100, rs, rt, imm};
      5'd12:   w = {6'b000101, rs, rt, imm};
      5'd13:   w = {6'b000001, rs, 5'b00001, imm};
      5'd14:   w = {6'b000001, rs, 5'b10001, imm};
      5'd15:   w = {6'b100011, rs, rt, imm};
      5'd16:   w = {6'b101011, rs, rt, imm};
      5'd17:   w = {6'b011100, rs, rt, rd, 5'b00000, 6'b000010};
      5'd18:   w = {6'b000010, target};
      5'd19:   w = {6'b000011, target};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  always_comb begin
    enc_word = encode(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
    op_legal = (in_op <= 5'd19);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_C;
      mem_wdata <= 32'h0000_0000;
      wr_addr   <= BASE_C;
      last_p0   <= 1'b0;
      count     <= '0;
      done      <= 1'b0;
      err_op    <= 1'b0;
      overflow  <= 1'b0;
    end else if (start && state != WRITE) begin
      // start restarts from any state except mid-write, which must complete
      state    <= LOAD;
      in_ready <= 1'b1;
      done     <= 1'b0;
      wr_addr  <= BASE_C;
      count    <= '0;
      err_op   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (count == DEPTH_C) begin
              overflow <= 1'b1;
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end else if (!op_legal) begin
              err_op <= 1'b1;
              if (in_last) begin
                state    <= DONE;
                in_ready <= 1'b0;
                done     <= 1'b1;
              end
            end else begin
              mem_wdata <= enc_word;
              mem_addr  <= wr_addr;
              last_p0   <= in_last;
              mem_we    <= 1'b1;
              in_ready  <= 1'b0;
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          mem_we  <= 1'b0;
          count   <= count + (ADDR_W+1)'(1);
          wr_addr <= wr_addr + ADDR_W'(1);
          if (last_p0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: transaction-level model checked every cycle,
// directed vectors with literal expected words, and a DEPTH=4 overflow instance.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_op = '0, in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        in_last = 1'b0;

  logic        in_ready, mem_we, done, err_op, overflow;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;

  logic        s_in_ready, s_mem_we, s_done, s_err_op, s_overflow;
  logic [7:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [8:0]  s_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .count(count), .done(done), .err_op(err_op),
    .overflow(overflow));

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0), .DEPTH(4)) dut_small (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .count(s_count), .done(s_done), .err_op(s_err_op),
    .overflow(s_overflow));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from opcode/funct tables and shifts.
  int r_funct[5]  = '{32, 34, 36, 37, 42};
  int i_opcode[8] = '{8, 12, 13, 14, 4, 5, 35, 43};

  function automatic bit [31:0] m_enc(input bit [31:0] op, input bit [31:0] rs,
                                      input bit [31:0] rt, input bit [31:0] rd,
                                      input bit [31:0] imm, input bit [31:0] tgt);
    bit [31:0] opc;
    if (op <= 4)       return (rs << 21) | (rt << 16) | (rd << 11) | r_funct[op];
    else if (op == 5)  return (rs << 21) | 32'd8;
    else if (op == 6)  return (rs << 21) | (rd << 11) | 32'd9;
    else if (op <= 12) begin
      opc = i_opcode[op - 7];
      return (opc << 26) | (rs << 21) | (rt << 16) | imm;
    end
    else if (op <= 14) return (32'd1 << 26) | (rs << 21) | ((op == 13 ? 32'd1 : 32'd17) << 16) | imm;
    else if (op <= 16) begin
      opc = i_opcode[op - 9];
      return (opc << 26) | (rs << 21) | (rt << 16) | imm;
    end
    else if (op == 17) return (32'd28 << 26) | (rs << 21) | (rt << 16) | (rd << 11) | 32'd2;
    else if (op <= 19) return ((op - 16) << 26) | tgt;
    return 32'd0;
  endfunction

  // Model: phase 0 idle, 1 accepting, 2 writing, 3 finished.
  int        m_phase = 0;
  bit [31:0] m_wdata = 0;
  int        m_addr = 0, m_next = 0, m_count = 0;
  bit        m_last = 0, m_err = 0, m_ovf = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_wdata = 0; m_addr = 0; m_next = 0; m_count = 0;
      m_last = 0; m_err = 0; m_ovf = 0;
    end else if (start && m_phase != 2) begin
      m_phase = 1; m_next = 0; m_count = 0; m_err = 0; m_ovf = 0;
    end else if (m_phase == 1 && in_valid) begin
      if (m_count == 256) begin
        m_ovf = 1; m_phase = 3;
      end else if (in_op > 19) begin
        m_err = 1;
        if (in_last) m_phase = 3;
      end else begin
        m_wdata = m_enc(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
        m_addr = m_next; m_last = in_last; m_phase = 2;
      end
    end else if (m_phase == 2) begin
      m_count++; m_next++;
      m_phase = m_last ? 3 : 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_phase == 1});
      chk("mem_we", {31'd0, mem_we}, {31'd0, m_phase == 2});
      chk("done", {31'd0, done}, {31'd0, m_phase == 3});
      chk("mem_addr", {24'd0, mem_addr}, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("count", {23'd0, count}, m_count);
      chk("err_op", {31'd0, err_op}, {31'd0, m_err});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  logic [7:0]  s_addr_q[$];
  logic [31:0] s_data_q[$];
  always @(negedge clk) begin
    if (s_mem_we) begin
      s_addr_q.push_back(s_mem_addr);
      s_data_q.push_back(s_mem_wdata);
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send(input int op, input int rs, input int rt, input int rd,
                      input int imm, input int tgt, input bit last,
                      input bit exp_we, input logic [31:0] exp_word, input int exp_addr);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 5'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm = 16'(imm); in_target = 26'(tgt); in_last = last;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL handshake_timeout actual=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    if (exp_we) begin
      chk("lit_mem_we", {31'd0, mem_we}, 32'd1);
      chk("lit_wdata", mem_wdata, exp_word);
      chk("lit_addr", {24'd0, mem_addr}, exp_addr);
      chk("lit_ready_in_write", {31'd0, in_ready}, 32'd0);
    end else begin
      chk("lit_no_write", {31'd0, mem_we}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk); #1 chk_en = 1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_count", {23'd0, count}, 32'd0);
    chk("rst_flags", {28'd0, done, err_op, overflow, mem_we}, 32'd0);

    // single ADDI
    pulse_start();
    send(7, 0, 8, 0, 5, 0, 0, 1, 32'h20080005, 0);
    @(negedge clk);
    chk("addi_count", {23'd0, count}, 32'd1);

    // back-to-back stream ending in J with in_last
    pulse_start();
    send(0, 8, 9, 10, 16'hFFFF, 0, 0, 1, 32'h01095020, 0);
    send(15, 29, 8, 3, 4, 0, 0, 1, 32'h8FA80004, 1);
    send(18, 1, 2, 3, 16'h1234, 26'h10, 1, 1, 32'h08000010, 2);
    @(negedge clk);
    chk("stream_done", {31'd0, done}, 32'd1);
    chk("stream_count", {23'd0, count}, 32'd3);

    // REGIMM rt forcing
    pulse_start();
    send(14, 4, 7, 0, 16'hFFFE, 0, 0, 1, 32'h0491FFFE, 0);
    send(13, 4, 7, 0, 16'hFFFE, 0, 0, 1, 32'h0481FFFE, 1);
    send(6, 31, 5, 31, 7, 0, 0, 1, 32'h03E0F809, 2);
    send(17, 1, 2, 3, 9, 0, 1, 1, 32'h70221802, 3);

    // illegal op mid-stream
    pulse_start();
    send(7, 0, 8, 0, 5, 0, 0, 1, 32'h20080005, 0);
    send(25, 1, 2, 3, 4, 5, 0, 0, 32'd0, 0);
    chk("err_sticky", {31'd0, err_op}, 32'd1);
    send(9, 1, 2, 0, 16'h00FF, 0, 0, 1, 32'h342200FF, 1);
    chk("err_still", {31'd0, err_op}, 32'd1);
    pulse_start();
    @(negedge clk);
    chk("err_cleared", {31'd0, err_op}, 32'd0);

    // DEPTH=4 overflow on the small instance
    s_addr_q.delete(); s_data_q.delete();
    for (int i = 0; i < 5; i++)
      send(7, 0, 8, 0, i, 0, 0, 1, 32'h20080000 | i, i);
    @(negedge clk);
    chk("ovf_flag", {31'd0, s_overflow}, 32'd1);
    chk("ovf_done", {31'd0, s_done}, 32'd1);
    chk("ovf_count", {23'd0, s_count}, 32'd4);
    chk("ovf_writes", s_addr_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < s_addr_q.size(); i++) begin
      chk("ovf_addr", {24'd0, s_addr_q[i]}, i);
      chk("ovf_data", s_data_q[i], 32'h20080000 | i);
    end

    // reset during WRITE
    pulse_start();
    send(7, 0, 8, 0, 5, 0, 0, 1, 32'h20080005, 0);
    send(8, 3, 4, 0, 16'h00F0, 0, 0, 1, 32'h306400F0, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstw_we", {31'd0, mem_we}, 32'd0);
    chk("rstw_count", {23'd0, count}, 32'd0);
    chk("rstw_ready", {31'd0, in_ready}, 32'd0);
    pulse_start();
    send(19, 0, 0, 0, 0, 26'h3FFFFFF, 1, 1, 32'h0FFFFFFF, 0);
    @(negedge clk);
    chk("rstw_done", {31'd0, done}, 32'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
